// File: rtl/regwr_pkg.sv
// rtl/regwr_pkg.sv - shared widths, state encoding and entry layout for the register-file write path
package regwr_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  // real_wr is low for writes aimed at the hardwired zero register
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              id;
    logic              real_wr;
  } entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, also used by the read-port scheduler
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  input  logic       accept,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // contention goes to whoever did not win last time
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (!accept) grant = 2'b00;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - arbitrates two write requesters into a single registered register-file write stage
module regfile_wr_arbiter
  import regwr_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              grant_id,
  output logic [7:0]        drop_cnt
);

  state_e     state;
  entry_t     entry;
  entry_t     next_entry;
  logic       last;
  logic [7:0] drop_q;
  logic       accept;
  logic [1:0] grant;
  logic       xfer;

  assign accept = (state == S_EMPTY) || !stall;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .last      (last),
    .accept    (accept),
    .grant     (grant)
  );

  assign req_ready = reset_n ? grant : 2'b00;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    next_entry.id      = req_ready[1];
    next_entry.addr    = req_ready[1] ? req_addr1 : req_addr0;
    next_entry.data    = req_ready[1] ? req_data1 : req_data0;
    next_entry.real_wr = (next_entry.addr != ZERO_REG);
  end

  // a stage that is being reset never writes, so an in-flight entry is lost
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_EMPTY;
      last   <= 1'b1;
      entry  <= '0;
      drop_q <= 8'd0;
    end else begin
      if (xfer) begin
        entry <= next_entry;
        last  <= next_entry.id;
        state <= S_FULL;
        if (!next_entry.real_wr) drop_q <= sat_inc8(drop_q);
      end else if (state == S_FULL && !stall) begin
        state <= S_EMPTY;
      end
    end
  end

  assign RegWrite      = reset_n && (state == S_FULL) && entry.real_wr && !stall;
  assign WriteRegister = entry.addr;
  assign WriteData     = entry.data;
  assign grant_id      = entry.id;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [1:0]  req_valid;
  logic [4:0]  req_addr0, req_addr1;
  logic [63:0] req_data0, req_data1;
  logic [1:0]  req_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic        grant_id;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int saw_rw;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .req_valid     (req_valid),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .req_ready     (req_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .grant_id      (grant_id),
    .drop_cnt      (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    stall     = 1'b0;
    req_valid = 2'b01;
    req_addr0 = 5'd0;
    req_addr1 = 5'd0;
    req_data0 = 64'd0;
    req_data1 = 64'd0;
    @(negedge clk);
    #1 check("ready_in_reset", req_ready, 2'b00);
    step();
    req_valid = 2'b00;
    step();
    reset_n = 1'b1;
    #1;
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_wreg", WriteRegister, 5'd0);
    check("rst_wdata", WriteData, 64'd0);
    check("rst_gid", grant_id, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    check("rst_ready", req_ready, 2'b00);

    // single request from requester 0
    req_valid = 2'b01; req_addr0 = 5'd5; req_data0 = 64'hDEAD;
    #1 check("single_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    check("single_rw", RegWrite, 1'b1);
    check("single_wreg", WriteRegister, 5'd5);
    check("single_wdata", WriteData, 64'hDEAD);
    check("single_gid", grant_id, 1'b0);
    step();
    #1 check("single_rw_after", RegWrite, 1'b0);

    // re-reset so the pointer starts fresh, then saturate both requesters
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req_valid = 2'b11;
    req_addr0 = 5'd1; req_data0 = 64'h100;
    req_addr1 = 5'd2; req_data1 = 64'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sat_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        check("sat_rw", RegWrite, 1'b1);
        check("sat_wreg", WriteRegister, (i % 2 == 1) ? 5'd1 : 5'd2);
        check("sat_gid", grant_id, (i % 2 == 1) ? 1'b0 : 1'b1);
      end
      step();
    end
    req_valid = 2'b00;
    #1;
    check("sat_tail_rw", RegWrite, 1'b1);
    check("sat_tail_wreg", WriteRegister, 5'd2);
    check("sat_tail_wdata", WriteData, 64'h200);
    check("sat_tail_ready", req_ready, 2'b00);
    step();
    #1 check("sat_drained", RegWrite, 1'b0);

    // stall hold with addr 7 in the stage and requester 1 waiting
    req_valid = 2'b01; req_addr0 = 5'd7; req_data0 = 64'h77;
    #1 check("stall_load_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b10; req_addr1 = 5'd3; req_data1 = 64'h33;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_rw", RegWrite, 1'b0);
      check("stall_ready", req_ready, 2'b00);
      check("stall_wreg", WriteRegister, 5'd7);
      step();
    end
    stall = 1'b0;
    #1;
    check("unstall_rw", RegWrite, 1'b1);
    check("unstall_wreg", WriteRegister, 5'd7);
    check("unstall_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    #1;
    check("refill_rw", RegWrite, 1'b1);
    check("refill_wreg", WriteRegister, 5'd3);
    check("refill_gid", grant_id, 1'b1);
    step();

    // writes to the zero register
    req_valid = 2'b10; req_addr1 = 5'd31; req_data1 = 64'h1234;
    #1 check("zero_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    #1;
    check("zero_rw", RegWrite, 1'b0);
    check("zero_wreg", WriteRegister, 5'd31);
    check("zero_drop1", drop_cnt, 8'd1);
    step();
    saw_rw = 0;
    req_valid = 2'b10;
    for (int i = 0; i < 299; i++) begin
      #1 if (RegWrite !== 1'b0) saw_rw++;
      step();
    end
    req_valid = 2'b00;
    #1;
    check("zero_never_rw", saw_rw, 0);
    check("zero_rw_last", RegWrite, 1'b0);
    check("zero_drop_sat", drop_cnt, 8'd255);
    step();

    // reset while the stage holds addr 9
    req_valid = 2'b01; req_addr0 = 5'd9; req_data0 = 64'h99;
    step();
    req_valid = 2'b11; req_addr0 = 5'd1; req_addr1 = 5'd2;
    reset_n = 1'b0;
    #1;
    check("midrst_rw", RegWrite, 1'b0);
    check("midrst_ready", req_ready, 2'b00);
    step();
    reset_n = 1'b1;
    #1;
    check("midrst_wreg", WriteRegister, 5'd0);
    check("midrst_wdata", WriteData, 64'd0);
    check("midrst_gid", grant_id, 1'b0);
    check("midrst_drop", drop_cnt, 8'd0);
    check("midrst_rw_after", RegWrite, 1'b0);
    check("midrst_first_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    check("midrst_wr_rw", RegWrite, 1'b1);
    check("midrst_wr_wreg", WriteRegister, 5'd1);
    step();

    // stall asserted while empty does not block acceptance
    stall = 1'b1;
    req_valid = 2'b01; req_addr0 = 5'd4; req_data0 = 64'h44;
    #1 check("estall_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    check("estall_rw0", RegWrite, 1'b0);
    check("estall_wreg", WriteRegister, 5'd4);
    step();
    #1 check("estall_rw1", RegWrite, 1'b0);
    stall = 1'b0;
    #1;
    check("estall_release_rw", RegWrite, 1'b1);
    check("estall_release_wdata", WriteData, 64'h44);
    step();
    #1 check("estall_done", RegWrite, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Two-requester write-port arbiter and sequencer for the 32 x 64-bit register file. It takes write requests from two independent sources, picks one per cycle in round-robin order, and registers it into a single-entry output stage. That stage drives the register file's write enable, which feeds the 5:32 write decoder, along with the write address and write data. Writes to the hardwired zero register are accepted and then discarded. A stall input freezes the output stage.

## Interface
- DATA_W, 64, write data width
- ADDR_W, 5, register address width (32 registers)
- ZERO_REG, 31, address whose writes are discarded
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  reset; synchronous, active-low
- stall  in  1  register file cannot take a write this cycle
- req_valid  in  2  per-requester write request
- req_addr0 / req_addr1  in  ADDR_W  target register, requester 0 / 1
- req_data0 / req_data1  in  DATA_W  write data, requester 0 / 1
- req_ready  out  2  one-hot or zero; a request transfers when req_valid[i] && req_ready[i]
- RegWrite  out  1  write enable to the register file / decoder En
- WriteRegister  out  ADDR_W  write address (decoder select)
- WriteData  out  DATA_W  write data
- grant_id  out  1  requester that owns the current output-stage entry
- drop_cnt  out  8  saturating count of discarded ZERO_REG writes

## Operation
- **Output stage:** one entry holding addr, data, id and a `real` flag.
- **FSM states:**
  - S_EMPTY: no entry.
  - S_FULL: entry present.
- **Accept condition:** accept = (state==S_EMPTY) || !stall. Pass-through drain and refill happens in the same cycle.
- **Arbitration (rr_arb2), when accept:**
  - If exactly one req_valid bit is set, that requester is granted.
  - If both are set, grant ~last. `last` is a 1-bit pointer, reset 1, so requester 0 wins first.
  - req_ready = grant & {2{accept}}.
- **On transfer:**
  - The entry loads the granted addr/data and id.
  - real = (addr != ZERO_REG).
  - last ← granted id.
  - State goes to S_FULL.
- **FSM transitions:**
  - S_EMPTY → S_FULL on transfer.
  - S_FULL → S_EMPTY when !stall and no transfer.
  - S_FULL → S_FULL on stall, holding the entry, or on !stall with a transfer, which drains and reloads.
- **RegWrite** = (state==S_FULL) && real && !stall.
  - WriteRegister, WriteData and grant_id always reflect the entry.
  - They hold their last value when empty; reset value 0.
- **ZERO_REG write:**
  - Handshakes normally.
  - Occupies the stage for one cycle.
  - Never raises RegWrite.
  - drop_cnt increments at transfer, saturates at 255.
- **Reset** (reset_n=0 at an edge):
  - State S_EMPTY, last=1, entry fields 0, drop_cnt=0.
  - req_ready=0 during the reset cycle.
  - An in-flight entry is discarded with no write.
- **Requester rule:** a requester must hold req_valid, addr and data stable until accepted. The arbiter does not check this.

## Timing
- Latency: transfer at edge N → RegWrite high during cycle N+1, assuming no stall.
- Throughput: one write per cycle with both requesters saturated, alternating 0,1,0,1…
- Combinational paths:
  - stall → RegWrite
  - stall, req_valid → req_ready
- No path from req_* to RegWrite/WriteRegister/WriteData; those are registered.
- Stall held k cycles with S_FULL: outputs stable, RegWrite=0, req_ready=0 for all k cycles. The write occurs in the first cycle with stall=0.
- Stall in S_EMPTY does not block acceptance; the entry simply waits.

## Structure
- **Package regwr_pkg:**
  - DATA_W, ADDR_W, ZERO_REG constants
  - state enum {S_EMPTY, S_FULL}
  - entry struct {addr, data, id, real}
- **Sub-module rr_arb2:** combinational grant from req_valid, last and accept. It is kept separate so it can be reused for the read-port scheduler.
- **Top:** state register, entry register, last pointer, drop counter.

## Test plan
- **Single request:** reset, then req_valid=01, addr0=5, data0=0xDEAD.
  - req_ready=01 in the same cycle.
  - Next cycle: RegWrite=1, WriteRegister=5, WriteData=0xDEAD, grant_id=0.
  - Following cycle: RegWrite=0.
- **Both requesters saturated:** both valid continuously, addr0=1, addr1=2.
  - Grants alternate 0,1,0,1.
  - RegWrite high every cycle after the first.
  - WriteRegister sequence 1,2,1,2.
- **Stall hold:** stall high for 3 cycles while S_FULL with addr 7.
  - RegWrite=0 and req_ready=00 for 3 cycles.
  - WriteRegister stays 7.
  - The write fires in the cycle stall drops.
- **Zero register:** req_valid=10, addr1=31.
  - Handshake completes.
  - RegWrite never rises.
  - drop_cnt 0→1.
  - 300 such writes → drop_cnt=255.
- **Reset mid-operation:** reset_n=0 while S_FULL with addr 9.
  - No write to 9.
  - All outputs 0 after the edge.
  - With both requesters valid after release, the first grant goes to requester 0.
- **Stall while empty:** stall=1 in S_EMPTY with req 0 valid.
  - req_ready=01.
  - Entry loaded; RegWrite stays 0 until stall=0.
